// File: rtl/mig_ctrl_model_pkg.sv
// Shared types and helpers for the on-chip MIG user-interface model.
package mig_model_pkg;

    // Access engine states: calibrating, ready, busy writing, busy reading.
    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_WRITE = 2'd2,
        ST_READ  = 2'd3
    } engine_state_t;

    // Which request type won the most recent write/read collision.
    typedef enum logic {
        RR_WRITE = 1'b0,
        RR_READ  = 1'b1
    } rr_grant_t;

    // Width of a counter that must hold values up to the largest delay.
    function automatic int cnt_width(input int init_c, input int rd_c, input int wr_c);
        int m;
        m = init_c;
        if (rd_c > m) m = rd_c;
        if (wr_c > m) m = wr_c;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/mig_ctrl_model_init_seq.sv
// Reset synchroniser and calibration delay counter for the MIG model.
module mig_init_seq #(
    parameter int INIT_CYCLES = 40,
    parameter int CNT_W       = 6
) (
    input  logic clk,
    input  logic rst,
    output logic ui_clk_sync_rst,
    output logic init_calib_complete
);

    logic [1:0]       sync_q, sync_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;

    assign ui_clk_sync_rst     = ~sync_q[1];
    assign init_calib_complete = done_q;

    // Shift a one through the synchroniser, then count out the calibration delay.
    always_comb begin
        sync_d = {sync_q[0], 1'b1};
        cnt_d  = cnt_q;
        done_d = done_q;
        if (!ui_clk_sync_rst && !done_q) begin
            if (cnt_q == CNT_W'(INIT_CYCLES - 1)) begin
                done_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // State registers; asynchronous assertion, synchronous release via sync_q.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= 2'b00;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

endmodule

// File: rtl/mig_ctrl_model.sv
// On-chip stand-in for the DDR MIG user interface: single-ported array,
// fixed write/read latency, round-robin collision arbitration, range flag.
module mig_ctrl_model
    import mig_model_pkg::*;
#(
    parameter int DATA_W      = 256,
    parameter int ADDR_W      = 25,
    parameter int MEM_AW      = 10,
    parameter int WR_LATENCY  = 2,
    parameter int RD_LATENCY  = 4,
    parameter int INIT_CYCLES = 40
) (
    input  logic                clk,
    input  logic                rst,
    output logic                ui_clk,
    output logic                ui_clk_sync_rst,
    output logic                init_calib_complete,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [DATA_W/8-1:0] wr_be,
    output logic                wr_busy,
    input  logic                rd_en,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic [DATA_W-1:0]   rd_data,
    output logic                rd_data_valid,
    output logic                rd_busy,
    output logic                addr_err
);

    localparam int BE_W  = DATA_W / 8;
    localparam int DEPTH = 1 << MEM_AW;
    localparam int CNT_W = cnt_width(INIT_CYCLES, RD_LATENCY, WR_LATENCY);

    engine_state_t     state_q, state_d;
    rr_grant_t         rr_q, rr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [MEM_AW-1:0] widx_q, widx_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [BE_W-1:0]   wbe_q, wbe_d;
    logic              wr_pend_q, wr_pend_d;
    logic              addr_err_q, addr_err_d;
    logic [DATA_W-1:0] rd_hold_q, rd_hold_d;
    logic [DATA_W-1:0] mem_rd_q;
    logic              rd_accept;
    logic              grant_wr, grant_rd;

    logic [MEM_AW-1:0] wr_idx, rd_idx;
    logic              wr_hi, rd_hi;

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    assign ui_clk = clk;

    mig_init_seq #(
        .INIT_CYCLES (INIT_CYCLES),
        .CNT_W       (CNT_W)
    ) u_init_seq (
        .clk                 (clk),
        .rst                 (rst),
        .ui_clk_sync_rst     (ui_clk_sync_rst),
        .init_calib_complete (init_calib_complete)
    );

    // Array index is the low address bits; any higher set bit is out of range.
    generate
        if (ADDR_W > MEM_AW) begin : g_addr_wide
            assign wr_idx = wr_addr[MEM_AW-1:0];
            assign rd_idx = rd_addr[MEM_AW-1:0];
            assign wr_hi  = |wr_addr[ADDR_W-1:MEM_AW];
            assign rd_hi  = |rd_addr[ADDR_W-1:MEM_AW];
        end else if (ADDR_W == MEM_AW) begin : g_addr_exact
            assign wr_idx = wr_addr;
            assign rd_idx = rd_addr;
            assign wr_hi  = 1'b0;
            assign rd_hi  = 1'b0;
        end else begin : g_addr_narrow
            assign wr_idx = {{(MEM_AW - ADDR_W){1'b0}}, wr_addr};
            assign rd_idx = {{(MEM_AW - ADDR_W){1'b0}}, rd_addr};
            assign wr_hi  = 1'b0;
            assign rd_hi  = 1'b0;
        end
    endgenerate

    // Engine next-state: arbitration, request capture and latency countdown.
    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        cnt_d      = cnt_q;
        widx_d     = widx_q;
        wdata_d    = wdata_q;
        wbe_d      = wbe_q;
        wr_pend_d  = 1'b0;
        addr_err_d = 1'b0;
        rd_hold_d  = rd_hold_q;
        rd_accept  = 1'b0;
        grant_wr   = 1'b0;
        grant_rd   = 1'b0;
        case (state_q)
            ST_INIT: begin
                if (init_calib_complete) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                grant_wr = wr_en && (!rd_en || rr_q == RR_READ);
                grant_rd = rd_en && !grant_wr;
                // Only a real collision moves the round-robin pointer.
                if (wr_en && rd_en) rr_d = grant_wr ? RR_WRITE : RR_READ;
                if (grant_wr) begin
                    state_d    = ST_WRITE;
                    cnt_d      = CNT_W'(WR_LATENCY - 1);
                    widx_d     = wr_idx;
                    wdata_d    = wr_data;
                    wbe_d      = wr_be;
                    wr_pend_d  = 1'b1;
                    addr_err_d = wr_hi;
                end else if (grant_rd) begin
                    state_d    = ST_READ;
                    cnt_d      = CNT_W'(RD_LATENCY - 1);
                    rd_accept  = 1'b1;
                    addr_err_d = rd_hi;
                end
            end
            ST_WRITE: begin
                if (cnt_q == '0) state_d = ST_IDLE;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            ST_READ: begin
                if (cnt_q == '0) begin
                    state_d   = ST_IDLE;
                    rd_hold_d = mem_rd_q;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    // Engine registers; reset aborts any in-flight access.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_INIT;
            rr_q       <= RR_READ;
            cnt_q      <= '0;
            widx_q     <= '0;
            wdata_q    <= '0;
            wbe_q      <= '0;
            wr_pend_q  <= 1'b0;
            addr_err_q <= 1'b0;
            rd_hold_q  <= '0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            cnt_q      <= cnt_d;
            widx_q     <= widx_d;
            wdata_q    <= wdata_d;
            wbe_q      <= wbe_d;
            wr_pend_q  <= wr_pend_d;
            addr_err_q <= addr_err_d;
            rd_hold_q  <= rd_hold_d;
        end
    end

    // Byte-masked commit of the captured write, one edge after accept.
    always_ff @(posedge clk) begin
        if (wr_pend_q) begin
            for (int b = 0; b < BE_W; b++) begin
                if (wbe_q[b]) mem[widx_q][b*8 +: 8] <= wdata_q[b*8 +: 8];
            end
        end
    end

    // Registered array read taken on the accept edge; held until the next read.
    always_ff @(posedge clk) begin
        if (rd_accept) mem_rd_q <= mem[rd_idx];
    end

    assign wr_busy       = (state_q != ST_IDLE);
    assign rd_busy       = (state_q != ST_IDLE);
    assign rd_data_valid = (state_q == ST_READ) && (cnt_q == '0);
    assign rd_data       = rd_data_valid ? mem_rd_q : rd_hold_q;
    assign addr_err      = addr_err_q;

endmodule

// File: tb/tb_mig_ctrl_model.sv
// Directed self-checking bench for the MIG user-interface model.
module tb_mig_ctrl_model;

    localparam int DATA_W = 256;
    localparam int ADDR_W = 25;
    localparam int BE_W   = DATA_W / 8;

    logic              clk;
    logic              rst;
    logic              ui_clk;
    logic              ui_clk_sync_rst;
    logic              init_calib_complete;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [BE_W-1:0]   wr_be;
    logic              wr_busy;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_data_valid;
    logic              rd_busy;
    logic              addr_err;

    int n_checks = 0;
    int n_errs   = 0;

    mig_ctrl_model #(
        .DATA_W      (DATA_W),
        .ADDR_W      (ADDR_W),
        .MEM_AW      (10),
        .WR_LATENCY  (2),
        .RD_LATENCY  (4),
        .INIT_CYCLES (40)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .ui_clk              (ui_clk),
        .ui_clk_sync_rst     (ui_clk_sync_rst),
        .init_calib_complete (init_calib_complete),
        .wr_en               (wr_en),
        .wr_addr             (wr_addr),
        .wr_data             (wr_data),
        .wr_be               (wr_be),
        .wr_busy             (wr_busy),
        .rd_en               (rd_en),
        .rd_addr             (rd_addr),
        .rd_data             (rd_data),
        .rd_data_valid       (rd_data_valid),
        .rd_busy             (rd_busy),
        .addr_err            (addr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((wr_busy || rd_busy) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check_eq("idle_timeout", DATA_W'(wr_busy), '0);
    endtask

    // Release reset off-edge and measure synchroniser and calibration delays.
    task automatic wait_calib();
        int n;
        int m;
        bit bad;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (ui_clk_sync_rst && n < 10);
        check_eq("sync_rst_edges", DATA_W'(n), DATA_W'(2));
        m = 0;
        bad = 1'b0;
        while (!init_calib_complete && m < 200) begin
            @(posedge clk); #1;
            m++;
            if (!init_calib_complete && (!wr_busy || !rd_busy)) bad = 1'b1;
        end
        check_eq("calib_cycles", DATA_W'(m), DATA_W'(40));
        check_eq("busy_before_calib", DATA_W'(bad), '0);
        n = 0;
        while ((wr_busy || rd_busy) && n < 5) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("busy_after_calib", DATA_W'({wr_busy, rd_busy}), '0);
        @(negedge clk);
    endtask

    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                            input logic [BE_W-1:0] be, output int bsy, output int aerr_cnt);
        wait_idle();
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
        @(posedge clk);
        @(negedge clk);
        wr_en = 1'b0;
        bsy = 0; aerr_cnt = 0;
        for (int k = 1; k <= 8; k++) begin
            if (wr_busy) bsy++;
            if (addr_err) aerr_cnt++;
            @(negedge clk);
        end
    endtask

    task automatic do_read(input logic [ADDR_W-1:0] a, output logic [DATA_W-1:0] d,
                           output int lat, output int bsy, output int vcnt,
                           output int aerr_cnt, output logic aerr_k1);
        wait_idle();
        rd_en = 1'b1; rd_addr = a;
        @(posedge clk);
        @(negedge clk);
        rd_en = 1'b0;
        d = '0; lat = 0; bsy = 0; vcnt = 0; aerr_cnt = 0; aerr_k1 = addr_err;
        for (int k = 1; k <= 8; k++) begin
            if (rd_data_valid) begin
                vcnt++;
                if (lat == 0) begin
                    lat = k;
                    d = rd_data;
                end
            end
            if (rd_busy) bsy++;
            if (addr_err) aerr_cnt++;
            @(negedge clk);
        end
    endtask

    // Both requests together; drop the expected winner, serve the loser later.
    task automatic collide(input bit write_first, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] wdat, output logic [DATA_W-1:0] rdat,
                           output int vk);
        bit seen_idle;
        wait_idle();
        wr_en = 1'b1; wr_addr = a; wr_data = wdat; wr_be = '1;
        rd_en = 1'b1; rd_addr = a;
        @(posedge clk);
        @(negedge clk);
        if (write_first) wr_en = 1'b0;
        else             rd_en = 1'b0;
        seen_idle = 1'b0; vk = 0; rdat = '0;
        for (int k = 1; k <= 16; k++) begin
            if (rd_data_valid && vk == 0) begin
                vk = k;
                rdat = rd_data;
            end
            if (!wr_busy) seen_idle = 1'b1;
            else if (seen_idle) begin
                wr_en = 1'b0;
                rd_en = 1'b0;
            end
            @(negedge clk);
        end
        wr_en = 1'b0; rd_en = 1'b0;
    endtask

    initial begin
        logic [DATA_W-1:0] d;
        logic [DATA_W-1:0] pat0;
        logic [DATA_W-1:0] pat1;
        logic [DATA_W-1:0] beef;
        logic [DATA_W-1:0] new1;
        logic [DATA_W-1:0] new2;
        int lat, bsy, vcnt, aerr, vk;
        logic aerr_k1;
        bit vseen;

        pat0 = {8{32'h0123_4567}} ^ 256'h1;
        pat1 = {8{32'h89ab_cdef}};
        beef = {8{32'hdead_beef}};
        new1 = {8{32'h5a5a_0001}};
        new2 = {8{32'ha5a5_0002}};

        rst = 1'b1;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0;
        rd_en = 1'b0; rd_addr = '0;
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state.
        check_eq("rst_sync_rst", DATA_W'(ui_clk_sync_rst), DATA_W'(1));
        check_eq("rst_calib", DATA_W'(init_calib_complete), '0);
        check_eq("rst_busy", DATA_W'({wr_busy, rd_busy}), DATA_W'(2'b11));
        check_eq("rst_valid", DATA_W'(rd_data_valid), '0);
        check_eq("rst_rd_data", rd_data, '0);
        check_eq("rst_addr_err", DATA_W'(addr_err), '0);
        check_eq("ui_clk_pass", DATA_W'(ui_clk), DATA_W'(clk));

        #2 rst = 1'b1;
        wait_calib();

        // Write i*9 to 0..19, then read back.
        for (int i = 0; i < 20; i++) begin
            do_write(ADDR_W'(i), DATA_W'(i * 9), '1, bsy, aerr);
            check_eq($sformatf("wr_busy_cycles[%0d]", i), DATA_W'(bsy), DATA_W'(2));
        end
        for (int i = 0; i < 20; i++) begin
            do_read(ADDR_W'(i), d, lat, bsy, vcnt, aerr, aerr_k1);
            check_eq($sformatf("rd_data[%0d]", i), d, DATA_W'(i * 9));
            check_eq($sformatf("rd_latency[%0d]", i), DATA_W'(lat), DATA_W'(4));
            check_eq($sformatf("rd_busy_cycles[%0d]", i), DATA_W'(bsy), DATA_W'(4));
            check_eq($sformatf("rd_valid_count[%0d]", i), DATA_W'(vcnt), DATA_W'(1));
        end
        check_eq("rd_data_hold", rd_data, DATA_W'(19 * 9));
        check_eq("no_addr_err_in_range", DATA_W'(aerr), '0);

        // Byte enables: low four bytes cleared, remainder kept; be=0 is a no-op.
        do_write(ADDR_W'(5), beef, '1, bsy, aerr);
        do_write(ADDR_W'(5), '0, 32'h0000_000F, bsy, aerr);
        do_read(ADDR_W'(5), d, lat, bsy, vcnt, aerr, aerr_k1);
        check_eq("be_partial", d, {{7{32'hdead_beef}}, 32'h0});
        do_write(ADDR_W'(5), '1, '0, bsy, aerr);
        check_eq("be_zero_busy_cycles", DATA_W'(bsy), DATA_W'(2));
        do_read(ADDR_W'(5), d, lat, bsy, vcnt, aerr, aerr_k1);
        check_eq("be_zero_no_update", d, {{7{32'hdead_beef}}, 32'h0});

        // Arbitration: first collision goes to the write, the repeat to the read.
        collide(1'b1, ADDR_W'(5), new1, d, vk);
        check_eq("arb1_read_cycle", DATA_W'(vk), DATA_W'(7));
        check_eq("arb1_read_sees_write", d, new1);
        collide(1'b0, ADDR_W'(5), new2, d, vk);
        check_eq("arb2_read_cycle", DATA_W'(vk), DATA_W'(4));
        check_eq("arb2_read_before_write", d, new1);
        do_read(ADDR_W'(5), d, lat, bsy, vcnt, aerr, aerr_k1);
        check_eq("arb2_write_served", d, new2);

        // Address range: aliased access with a one-cycle error pulse.
        do_write(ADDR_W'(0), pat0, '1, bsy, aerr);
        check_eq("wr_in_range_err", DATA_W'(aerr), '0);
        do_read(25'h400, d, lat, bsy, vcnt, aerr, aerr_k1);
        check_eq("oor_read_alias", d, pat0);
        check_eq("oor_read_err_k1", DATA_W'(aerr_k1), DATA_W'(1));
        check_eq("oor_read_err_cnt", DATA_W'(aerr), DATA_W'(1));
        do_write(25'h1401, pat1, '1, bsy, aerr);
        check_eq("oor_write_err_cnt", DATA_W'(aerr), DATA_W'(1));
        do_read(ADDR_W'(1), d, lat, bsy, vcnt, aerr, aerr_k1);
        check_eq("oor_write_alias", d, pat1);

        // Reset two cycles into a read: no valid strobe, memory survives.
        wait_idle();
        rd_en = 1'b1; rd_addr = ADDR_W'(0);
        @(posedge clk);
        @(negedge clk);
        rd_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("midrd_busy", DATA_W'({wr_busy, rd_busy}), DATA_W'(2'b11));
        check_eq("midrd_rd_data", rd_data, '0);
        check_eq("midrd_calib", DATA_W'(init_calib_complete), '0);
        check_eq("midrd_sync_rst", DATA_W'(ui_clk_sync_rst), DATA_W'(1));
        vseen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (rd_data_valid) vseen = 1'b1;
        end
        #2 rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            if (rd_data_valid) vseen = 1'b1;
        end
        check_eq("midrd_no_valid", DATA_W'(vseen), '0);
        @(negedge clk);
        rst = 1'b0;
        #2 rst = 1'b1;
        wait_calib();
        do_read(ADDR_W'(0), d, lat, bsy, vcnt, aerr, aerr_k1);
        check_eq("midrd_mem_kept", d, pat0);
        check_eq("midrd_latency_after", DATA_W'(lat), DATA_W'(4));

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
